// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD  = 3'd0,
    WAIT_LOCK   = 3'd1,
    LOCK_STABLE = 3'd2,
    READY       = 3'd3,
    FAULT       = 3'd4
  } seq_state_e;

  // Counter only ever needs to reach (longest phase - 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_lock_sync.sv
// Multi-flop bit synchronizer, async active-high reset to 0.
module lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / lock-qualification sequencer for the board PLL, clocked by refclk.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 100,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                           refclk,
  input  logic                           reset,
  input  logic                           pll_lock,
  input  logic                           soft_restart,
  output logic                           pll_reset,
  output logic                           clk_ready,
  output logic                           fault,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [2:0]                     seq_state
);

  localparam int unsigned CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  logic lock_s;

  lock_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(refclk),
    .rst(reset),
    .d  (pll_lock),
    .q  (lock_s)
  );

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          pll_reset_q, pll_reset_d;
  logic          clk_ready_q, clk_ready_d;
  logic          fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_q + CW'(1);

    if (soft_restart) begin
      state_d = RESET_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // Lock seen on the timeout cycle still counts as lock.
          if (lock_s) begin
            state_d = LOCK_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RW'(1);
              state_d = RESET_HOLD;
            end else begin
              state_d = FAULT;
            end
          end
        end
        LOCK_STABLE: begin
          if (!lock_s) state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = READY;
        end
        READY: begin
          if (!lock_s) begin
            state_d = RESET_HOLD;
            retry_d = '0;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = RESET_HOLD;
      endcase
    end

    // Restart inside RESET_HOLD keeps the state but must still restart the count.
    if (soft_restart || (state_d != state_q)) cnt_d = '0;

    pll_reset_d = (state_d == RESET_HOLD) || (state_d == FAULT);
    clk_ready_d = (state_d == READY);
    fault_d     = (state_d == FAULT);
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      clk_ready_q <= clk_ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign clk_ready = clk_ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: a phase-level model predicts output changes, a monitor matches DUT changes.
module tb_pll_lock_sequencer;

  localparam int unsigned RST_C  = 4;
  localparam int unsigned TO_C   = 20;
  localparam int unsigned STB_C  = 8;
  localparam int unsigned MAXR   = 2;
  localparam int unsigned SYNC_N = 2;

  localparam int PH_HOLD = 0, PH_WAIT = 1, PH_STABLE = 2, PH_READY = 3, PH_FAULT = 4;

  logic       refclk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       soft_restart = 1'b0;
  logic       pll_reset, clk_ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] seq_state;

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TO_C),
    .STABLE_CYCLES(STB_C),
    .MAX_RETRY    (MAXR),
    .SYNC_STAGES  (SYNC_N)
  ) dut (
    .refclk      (refclk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .soft_restart(soft_restart),
    .pll_reset   (pll_reset),
    .clk_ready   (clk_ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .seq_state   (seq_state)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  localparam logic [7:0] RESET_VEC = 8'b1_0_0_00_000;

  // Behavioural model: lock passes through a SYNC_N-deep delay line, phases follow the rules.
  int   ph = PH_HOLD;
  int   elapsed = 0;
  int   retries = 0;
  logic lock_hist[$] = '{1'b0, 1'b0};
  logic [7:0] exp_prev = RESET_VEC;

  always @(posedge refclk) begin
    logic lock_seen;
    logic [7:0] ev;
    exp_t e;
    cyc++;
    #1;
    if (reset) begin
      ph = PH_HOLD; elapsed = 0; retries = 0;
      lock_hist = '{1'b0, 1'b0};
    end else begin
      lock_seen = lock_hist.pop_front();
      lock_hist.push_back(pll_lock);
      if (soft_restart) begin
        ph = PH_HOLD; elapsed = 0; retries = 0;
      end else begin
        int nph;
        elapsed++;
        nph = ph;
        case (ph)
          PH_HOLD:   if (elapsed == RST_C) nph = PH_WAIT;
          PH_WAIT:   if (lock_seen) nph = PH_STABLE;
                     else if (elapsed == TO_C) begin
                       if (retries < MAXR) begin retries++; nph = PH_HOLD; end
                       else nph = PH_FAULT;
                     end
          PH_STABLE: if (!lock_seen) nph = PH_WAIT;
                     else if (elapsed == STB_C) nph = PH_READY;
          PH_READY:  if (!lock_seen) begin nph = PH_HOLD; retries = 0; end
          default:   nph = ph;
        endcase
        if (nph != ph) elapsed = 0;
        ph = nph;
      end
    end
    ev = {(ph == PH_HOLD || ph == PH_FAULT), (ph == PH_READY), (ph == PH_FAULT),
          2'(retries), 3'(ph)};
    if (ev !== exp_prev) begin
      e.cyc = cyc; e.v = ev;
      exp_q.push_back(e);
    end
    exp_prev = ev;
  end

  // Monitor: every DUT output change must match the next predicted change, same cycle.
  logic [7:0] dut_prev = RESET_VEC;
  always @(posedge refclk) begin
    logic [7:0] cur;
    exp_t e;
    #2;
    cur = {pll_reset, clk_ready, fault, retry_cnt, seq_state};
    if (cur !== dut_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d actual=%b required=no_change", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v !== cur) begin
          failures++;
          $display("FAIL transition actual=cyc%0d:%b required=cyc%0d:%b", cyc, cur, e.cyc, e.v);
        end
      end
      dut_prev = cur;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic pulse_restart();
    soft_restart = 1'b1;
    cycles(1);
    soft_restart = 1'b0;
  endtask

  initial begin
    cycles(3);
    check("reset_pll_reset", int'(pll_reset), 1);
    check("reset_clk_ready", int'(clk_ready), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_retry", int'(retry_cnt), 0);
    check("reset_state", int'(seq_state), PH_HOLD);
    reset = 1'b0;

    // Nominal bring-up with a random lock delay inside the timeout window
    cycles(RST_C + $urandom_range(2, 12));
    pll_lock = 1'b1;
    cycles(25);
    check("nominal_ready", int'(clk_ready), 1);

    // Lock loss from READY
    pll_lock = 1'b0;
    cycles($urandom_range(1, 3));
    pll_lock = 1'b1;
    cycles(35);

    // Glitchy lock: short burst, one-cycle dropout, then steady lock
    pll_lock = 1'b0;
    pulse_restart();
    cycles(RST_C + 3);
    pll_lock = 1'b1;
    cycles($urandom_range(2, 8));
    pll_lock = 1'b0;
    cycles(1);
    pll_lock = 1'b1;
    cycles(25);

    // Randomly toggling lock with occasional restarts
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 11) == 0) pll_lock = ~pll_lock;
      soft_restart = ($urandom_range(0, 79) == 0);
      cycles(1);
    end
    soft_restart = 1'b0;

    // Timeout / retry into FAULT
    pll_lock = 1'b0;
    pulse_restart();
    cycles(3 * (RST_C + TO_C) + 30);
    check("fault_flag", int'(fault), 1);
    check("fault_pll_reset", int'(pll_reset), 1);
    check("fault_state", int'(seq_state), PH_FAULT);
    check("fault_retry", int'(retry_cnt), MAXR);

    // Recovery from FAULT via soft_restart with lock held
    pll_lock = 1'b1;
    pulse_restart();
    cycles(RST_C + STB_C + 10);
    check("recover_ready", int'(clk_ready), 1);

    // Async reset while in LOCK_STABLE
    pll_lock = 1'b0;
    cycles(4);
    pll_lock = 1'b1;
    begin
      int n = 0;
      while (seq_state != 3'(PH_STABLE) && n < 60) begin cycles(1); n++; end
      check("reach_lock_stable", int'(seq_state), PH_STABLE);
    end
    #2 reset = 1'b1;
    #1;
    check("async_pll_reset", int'(pll_reset), 1);
    check("async_clk_ready", int'(clk_ready), 0);
    check("async_fault", int'(fault), 0);
    check("async_retry", int'(retry_cnt), 0);
    check("async_state", int'(seq_state), PH_HOLD);
    cycles(3);
    reset = 1'b0;
    cycles(RST_C + STB_C + 10);

    cycles(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
